// File: rtl/disp_pkg.sv
// Shared types, glyph constants and hex glyph lookup for the result display.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned IDX_W  = 3;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex nibble; dp stays off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
        logic [7:0] g;
        case (nibble)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one shift per cycle.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done,
    output logic              Busy
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [2:0]          k_q, k_d;
    logic [BCD_W-1:0]    adj_c;
    logic                busy_q;
    logic                done_q;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int n = 0; n < 3; n++) begin
            if (r[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            bcd_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            bcd_q   <= bcd_d;
            k_q     <= k_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        bcd_d   = bcd_q;
        k_d     = k_q;
        adj_c   = dabble_adjust(bcd_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_d   = bin;
                    bcd_d   = '0;
                    k_d     = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, cap_d} = {adj_c[BCD_W-2:0], cap_q, 1'b0};
                k_d            = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bcd  = bcd_q;
    assign done = done_q;
    assign Busy = busy_q;

endmodule

// File: rtl/shift_result_display.sv
// Multiplexed 8-digit display of the shifter result in binary or hex + decimal.
module shift_result_display
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  Din,
    input  logic        Fmt,
    output logic [7:0]  Seg,
    output logic [7:0]  An,
    output logic        Busy
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DATA_W-1:0] last_val_q;
    logic [DATA_W-1:0] pend_val_q;
    logic [DATA_W-1:0] disp_val_q;
    logic [BCD_W-1:0]  disp_bcd_q;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] an_q;
    logic [7:0]        seg_q;

    logic              start_c;
    logic              wrap_c;
    logic [7:0]        glyph_c;
    logic [BCD_W-1:0]  conv_bcd;
    logic              conv_done;
    logic              conv_busy;

    // New values are only accepted while the converter is idle.
    assign start_c = (Din != last_val_q) && !conv_busy;

    bin2bcd_seq u_bin2bcd (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (start_c),
        .bin   (Din),
        .bcd   (conv_bcd),
        .done  (conv_done),
        .Busy  (conv_busy)
    );

    // Value and BCD are committed together so the panel never mixes old and new.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_val_q <= '0;
            pend_val_q <= '0;
            disp_val_q <= '0;
            disp_bcd_q <= '0;
        end else begin
            if (start_c) begin
                pend_val_q <= Din;
            end
            if (conv_done) begin
                disp_val_q <= pend_val_q;
                disp_bcd_q <= conv_bcd;
                last_val_q <= pend_val_q;
            end
        end
    end

    assign wrap_c = (pre_q == PRE_W'(SCAN_DIV - 1));

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (wrap_c) begin
            pre_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Glyph for the digit about to be enabled.
    always_comb begin
        glyph_c = SEG_BLANK;
        if (!Fmt) begin
            glyph_c = disp_val_q[idx_d] ? SEG_1 : SEG_0;
        end else begin
            case (idx_d)
                3'd7:    glyph_c = hex_glyph(disp_val_q[7:4]);
                3'd6:    glyph_c = hex_glyph(disp_val_q[3:0]);
                3'd2:    glyph_c = hex_glyph(disp_bcd_q[11:8]);
                3'd1:    glyph_c = hex_glyph(disp_bcd_q[7:4]);
                3'd0:    glyph_c = hex_glyph(disp_bcd_q[3:0]);
                default: glyph_c = SEG_BLANK;
            endcase
        end
    end

    // Scan outputs move only on prescaler wrap, independent of conversions.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFE;
            seg_q <= SEG_0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            if (wrap_c) begin
                an_q  <= ~(DIGITS'(1) << idx_d);
                seg_q <= glyph_c;
            end
        end
    end

    assign An   = an_q;
    assign Seg  = seg_q;
    assign Busy = conv_busy;

endmodule

// File: tb/tb_shift_result_display.sv
// Scoreboarded bench: stimulus queues expected shown values, a monitor checks scan output.
module tb_shift_result_display;

    localparam int unsigned SCAN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       fmt;
    logic [7:0] seg;
    logic [7:0] an;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_acc;
    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    shift_result_display #(.SCAN_DIV(SCAN)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .Din   (din),
        .Fmt   (fmt),
        .Seg   (seg),
        .An    (an),
        .Busy  (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected glyph for digit d of value v, from plain arithmetic.
    function automatic logic [7:0] model_glyph(input logic [7:0] v, input logic f, input int d);
        int vi;
        vi = int'(v);
        if (!f) return (((vi >> d) & 1) != 0) ? 8'hF9 : 8'hC0;
        case (d)
            7:       return glyph_tab[vi / 16];
            6:       return glyph_tab[vi % 16];
            2:       return glyph_tab[vi / 100];
            1:       return glyph_tab[(vi / 10) % 10];
            0:       return glyph_tab[vi % 10];
            default: return 8'hFF;
        endcase
    endfunction

    // Monitor: scan sequence, hold time, glyphs and Busy pulse length.
    logic [7:0] an_prev   = 8'hFE;
    int         hold      = 0;
    bit         skip_hold = 1'b1;
    logic       busy_prev = 1'b0;
    int         busy_len  = 0;
    logic [7:0] shown     = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            an_prev   = 8'hFE;
            hold      = 0;
            skip_hold = 1'b1;
            busy_prev = 1'b0;
            busy_len  = 0;
            shown     = 8'h00;
        end else begin
            if (an != an_prev) begin
                int d;
                d = -1;
                for (int i = 0; i < 8; i++) begin
                    if (!an[i]) d = i;
                end
                check("an_rotate", an, {an_prev[6:0], an_prev[7]});
                if (!skip_hold) check("scan_hold", hold, SCAN);
                check($sformatf("seg_digit%0d", d), seg, model_glyph(shown, fmt, d));
                an_prev   = an;
                hold      = 1;
                skip_hold = 1'b0;
            end else begin
                hold++;
            end
            if (busy) busy_len++;
            if (busy_prev && !busy) begin
                check("busy_len", busy_len, 9);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL busy_fall: conversion finished with nothing expected at %0t", $time);
                end else begin
                    shown = exp_q.pop_front();
                end
            end
            if (!busy) busy_len = 0;
            busy_prev = busy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply(input logic [7:0] v);
        din = v;
        if (v != last_acc) begin
            exp_q.push_back(v);
            last_acc = v;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            step(1);
            n++;
        end
        check("idle_timeout", 32'(n < 300), 1);
    endtask

    task automatic show(input logic [7:0] v);
        apply(v);
        wait_idle();
        step(40);
    endtask

    initial begin
        bit saw;
        rst_n    = 1'b0;
        din      = 8'h00;
        fmt      = 1'b1;
        last_acc = 8'h00;
        step(1);
        check("reset_an", an, 8'hFE);
        check("reset_seg", seg, 8'hC0);
        check("reset_busy", busy, 0);
        step(3);
        rst_n = 1'b1;

        saw = 1'b0;
        repeat (20) begin
            step(1);
            if (busy) saw = 1'b1;
        end
        check("busy_idle_zero", saw, 0);

        apply(8'hA5);
        step(1);
        check("busy_rise", busy, 1);
        wait_idle();
        step(40);

        fmt = 1'b0;
        step(40);
        fmt = 1'b1;

        apply(8'h0F);
        step(4);
        apply(8'hFF);
        wait_idle();
        step(40);

        apply(8'h64);
        step(5);
        rst_n = 1'b0;
        #1;
        check("midrst_an", an, 8'hFE);
        check("midrst_seg", seg, 8'hC0);
        check("midrst_busy", busy, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("busy_after_rst", busy, 1);
        wait_idle();
        step(40);

        show(8'hFF);
        show(8'h00);
        show(8'h09);
        show(8'h63);

        repeat (15) begin
            fmt = 1'($urandom_range(0, 1));
            apply(8'($urandom_range(0, 255)));
            wait_idle();
            step(int'($urandom_range(33, 45)));
        end

        step(5);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/shift_result_display.md
# shift_result_display

Downstream display stage for the 8-bit shifting register: consumes its 8-bit result (`Dout`) and drives an 8-digit, multiplexed, common-anode seven-segment display. It shows either the value in binary (one bit per digit) or as hex plus unsigned decimal. The decimal digits come from a sequential double-dabble converter. Display registers update atomically only after a completed conversion, so the panel never shows a half-updated value.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit-scan step; legal range ≥ 2.
- `Clk` input 1: system clock; everything is on the rising edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `Din` input 8: value to display; connected to the shifter's `Dout`.
- `Fmt` input 1: display format. 0 = binary; 1 = hex + decimal.
- `Seg` output 8: segments `{dp,g,f,e,d,c,b,a}`, active low; registered.
- `An` output 8: digit enables, active low, one-hot; registered. `An[7]` is the leftmost digit.
- `Busy` output 1: high while a conversion is in flight; registered.

## Operation
- **Internal registers:**
  - `last_val[7:0]`: last accepted value.
  - `cap[7:0]`: shift source.
  - `bcd[11:0]`: working BCD.
  - `disp_val[7:0]` and `disp_bcd[11:0]`: shown value.
  - Prescaler `pre`: 0..SCAN_DIV-1.
  - Scan index `idx[2:0]`.
- **FSM states:** IDLE, CONV, DONE.
  - IDLE: if `Din != last_val`: `cap<=Din`, `bcd<=0`, `k<=0`, go to CONV. Otherwise stay.
  - CONV, one iteration per cycle:
    - Each BCD nibble ≥ 5 gets +3.
    - Then `{bcd,cap}` shifts left by 1; `k<=k+1`.
    - After iteration 8 (k=7), go to DONE.
  - DONE: `disp_bcd<=bcd`, `disp_val<=Din value captured at start`, `last_val<=` same value; go to IDLE.
- **Changes during conversion:** `Din` changes during CONV/DONE are ignored. They are detected in the next IDLE cycle because the compare is against `last_val`.
- **Scan:**
  - `pre` increments every cycle and wraps to 0 at SCAN_DIV-1.
  - On wrap, `idx<=idx+1` (mod 8).
  - `An<=~(8'b1<<idx_next)`.
  - `Seg<=glyph(idx_next)`.
- **Glyphs, Fmt=0:** digit i shows `disp_val[i]` as '0' (C0) or '1' (F9).
- **Glyphs, Fmt=1:**
  - Digit 7: `disp_val[7:4]` in hex.
  - Digit 6: `disp_val[3:0]` in hex.
  - Digits 5..3: blank (FF).
  - Digits 2..0: hundreds, tens, ones from `disp_bcd`, with no leading-zero suppression.
- **Hex glyph codes:** 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E. `dp` is always off.
- **Fmt changes:** take effect at the next scan step. No reconversion.

## Timing
- **Reset values** (asynchronous, immediate):
  - Registers: state=IDLE, all data registers 0, `pre=0`, `idx=0`.
  - Outputs: `An=8'hFE`, `Seg=8'hC0`, `Busy=0`.
- **Conversion latency:**
  - Edge E1 samples a mismatch; `Busy` rises after E1.
  - 8 CONV edges follow (E2..E9), then the DONE edge E10.
  - After E10, `disp_*` hold the new value and `Busy=0`. `Busy` is high for exactly 9 cycles.
- **Scan rate:** with a static input, each digit stays enabled for exactly SCAN_DIV cycles. `An`/`Seg` change only on the edge where `pre` wraps.
- **Mid-conversion display:** a conversion never disturbs scan timing. The glyph changes on the first scan step after E10.
- **Back-to-back changes:** a new change arriving at E10 starts its conversion at E11.
- **Reset mid-conversion:** the conversion is aborted and all registers take reset values. After release, a nonzero `Din` starts a fresh conversion on the first edge.

## Structure
- **Package `disp_pkg`:**
  - `state_t` enum (IDLE/CONV/DONE).
  - `DIGITS=8`.
  - Glyph constants for 0-F and `SEG_BLANK=8'hFF`.
  - Function `hex_glyph(nibble)`.
- **Sub-module `bin2bcd_seq`:**
  - Contains the FSM, the double-dabble datapath and `Busy`.
  - Ports: `Clk`, `Rst_n`, `start`, `bin[7:0]`, `bcd[11:0]`, `done`.
- **Top level:** change detect, display registers, prescaler/scan and glyph mux.

## Test plan
- **Reset:** assert `Rst_n=0` mid-run -> immediately `An=FE`, `Seg=C0`, `Busy=0`. Holding `Din=0` after release -> `Busy` never rises.
- **Conversion, Fmt=1, SCAN_DIV=4:** `Din=8'hA5` -> `Busy` high for 9 cycles. Then the scan shows digit7=88, digit6=92, digits5..3=FF, digit2=F9, digit1=82, digit0=92 (165).
- **Binary format:** `Fmt=0`, `Din=8'hA5` -> digits 7..0 show F9,C0,F9,C0,C0,F9,C0,F9. Each `An` pattern is held 4 cycles and cycles FE→FD→…→7F→FE.
- **Change during conversion:** `Din` changes 8'h0F→8'hFF during CONV -> first displays 015 (hex 0F), then `Busy` re-rises the cycle after DONE and the display ends at 255 (hex FF).
- **Reset mid-conversion:** pulse `Rst_n` low in CONV cycle 4 with `Din=8'h64` held -> after release, `Busy` rises on the first edge and the display shows 100 / hex 64.
- **Boundary values:** `Din=8'h00` after `8'hFF`, then 8'h09 and 8'h63 -> decimal 000, 009, 099 exactly. Verifies the add-3 handling at nibble values 5..9.
